output_port_allocator: RTL and testbench

Per-output-port allocator for the mesh router's switch stage. Collects routing requests from the four input link controllers that can reach this output and grants the port to one packet at a time, using round-robin priority. It holds the grant until the packet's tail flit has been transferred. It also tracks credits for the downstream buffer, so a flit is forwarded only when the neighbour has a free slot. Its one-hot grant drives the crossbar select for this output.

---
 rtl/output_port_allocator_if.sv | 31 +++
 rtl/output_port_allocator.sv | 128 ++++++++++++
 tb/tb_output_port_allocator.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_port_allocator_if.sv
// Switch-stage bundle between the input link controllers and one output port allocator.
// The master drives requests, tails and credits; the slave (allocator) drives the crossbar select and status.
interface output_port_allocator_if;
  logic [3:0] request_vector_din;
  logic [3:0] tail_vector_din;
  logic       credit_din;
  logic [3:0] grant_vector_dout;
  logic       transfer_strobe_dout;
  logic       port_busy_dout;
  logic [3:0] credit_count_dout;

  modport master (
    output request_vector_din,
    output tail_vector_din,
    output credit_din,
    input  grant_vector_dout,
    input  transfer_strobe_dout,
    input  port_busy_dout,
    input  credit_count_dout
  );

  modport slave (
    input  request_vector_din,
    input  tail_vector_din,
    input  credit_din,
    output grant_vector_dout,
    output transfer_strobe_dout,
    output port_busy_dout,
    output credit_count_dout
  );
endinterface

// File: rtl/output_port_allocator.sv
// Round-robin output port allocator: grants one packet at a time and holds the grant until its tail moves.
// Grant one cycle after request; strobe is combinational; stalls with grant held while downstream credits are zero.
`ifndef PE
`define PE    3'd0
`endif
`ifndef X_POS
`define X_POS 3'd1
`endif
`ifndef Y_POS
`define Y_POS 3'd2
`endif
`ifndef X_NEG
`define X_NEG 3'd3
`endif
`ifndef Y_NEG
`define Y_NEG 3'd4
`endif

module output_port_allocator #(
  parameter logic [2:0] PORT_DIR     = `X_POS,
  parameter int         BUFFER_DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  output_port_allocator_if.slave port
);

  if (BUFFER_DEPTH < 1 || BUFFER_DEPTH > 15) begin : g_bad_depth
    $error("output_port_allocator: BUFFER_DEPTH must be 1..15");
  end
  if (PORT_DIR > `Y_NEG) begin : g_bad_dir
    $error("output_port_allocator: PORT_DIR out of range");
  end

  localparam logic [3:0] DEPTH4 = 4'(BUFFER_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic [3:0] grant;
  logic [1:0] rr_pointer;
  logic [3:0] credit_count;
  logic       port_busy;

  logic       strobe;
  logic       granted_req;
  logic       granted_tail;
  logic [1:0] grant_idx;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       pick_found;

  assign granted_req  = |(grant & port.request_vector_din);
  assign granted_tail = |(grant & port.tail_vector_din);
  assign strobe       = (state == ACTIVE) && granted_req && (credit_count != 4'd0);

  // Search starts at rr_pointer and wraps, so the channel after the last winner has top priority.
  always_comb begin
    pick_idx   = rr_pointer;
    pick_found = 1'b0;
    cand       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_pointer + 2'(k);
      if (!pick_found && port.request_vector_din[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (grant[k]) grant_idx = 2'(k);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 4'd0;
      rr_pointer <= 2'd0;
      port_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant     <= 4'b0001 << pick_idx;
            state     <= ACTIVE;
            port_busy <= 1'b1;
          end
        end
        ACTIVE: begin
          // A dropped request (abort) releases the port exactly like a tail transfer.
          if ((strobe && granted_tail) || !granted_req) begin
            grant      <= 4'd0;
            rr_pointer <= grant_idx + 2'd1;
            state      <= IDLE;
            port_busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= 4'd0;
          port_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_count <= DEPTH4;
    end else begin
      case ({strobe, port.credit_din})
        2'b10:   credit_count <= credit_count - 4'd1;
        2'b01:   if (credit_count != DEPTH4) credit_count <= credit_count + 4'd1;
        default: credit_count <= credit_count;
      endcase
    end
  end

  assign port.grant_vector_dout    = grant;
  assign port.transfer_strobe_dout = strobe;
  assign port.port_busy_dout       = port_busy;
  assign port.credit_count_dout    = credit_count;

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench: DUT a (depth 4) and DUT b (depth 2) share clock and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_output_port_allocator;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [7:0] sb_q[$];

  output_port_allocator_if a ();
  output_port_allocator_if b ();

  output_port_allocator #(.PORT_DIR(3'd1), .BUFFER_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .port(a.slave));
  output_port_allocator #(.PORT_DIR(3'd1), .BUFFER_DEPTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .port(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input bit sel, input logic [3:0] req, input logic [3:0] tail,
                     input logic cr, output logic st, output logic [3:0] gr,
                     output logic [3:0] cc, output logic bz);
    if (sel) begin
      b.request_vector_din = req; b.tail_vector_din = tail; b.credit_din = cr;
    end else begin
      a.request_vector_din = req; a.tail_vector_din = tail; a.credit_din = cr;
    end
    @(negedge clk);
    if (sel) begin
      st = b.transfer_strobe_dout; gr = b.grant_vector_dout;
      cc = b.credit_count_dout;    bz = b.port_busy_dout;
    end else begin
      st = a.transfer_strobe_dout; gr = a.grant_vector_dout;
      cc = a.credit_count_dout;    bz = a.port_busy_dout;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a.request_vector_din = 4'd0; a.tail_vector_din = 4'd0; a.credit_din = 1'b0;
    b.request_vector_din = 4'd0; b.tail_vector_din = 4'd0; b.credit_din = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    a.request_vector_din = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a.grant_vector_dout !== 4'd0 || a.transfer_strobe_dout !== 1'b0 || a.port_busy_dout !== 1'b0) begin
      failures++;
      $display("FAIL rst_outputs got gr=%b st=%b bz=%b want 0000/0/0",
               a.grant_vector_dout, a.transfer_strobe_dout, a.port_busy_dout);
    end
    checks++;
    if (a.credit_count_dout !== 4'd4) begin
      failures++; $display("FAIL rst_credit_a got=%0d want=4", a.credit_count_dout);
    end
    checks++;
    if (b.credit_count_dout !== 4'd2) begin
      failures++; $display("FAIL rst_credit_b got=%0d want=2", b.credit_count_dout);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_single_packet();
    logic st, bz;
    logic [3:0] gr, cc;
    logic [7:0] e;
    int sent, n;
    do_reset();
    cyc(0, 4'b0100, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (st !== 1'b0 || gr !== 4'd0) begin
      failures++; $display("FAIL sp_arb got st=%b gr=%b want 0/0000", st, gr);
    end
    for (int k = 0; k < 3; k++) sb_q.push_back({4'b0100, 4'(4 - k)});
    sent = 0; n = 0;
    while (sent < 3 && n < 8) begin
      cyc(0, 4'b0100, (sent == 2) ? 4'b0100 : 4'b0000, 1'b0, st, gr, cc, bz);
      n++;
      if (st) begin
        sent++;
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hFF;
        checks++;
        if ({gr, cc} !== e) begin
          failures++; $display("FAIL sp_flit%0d got gr=%b cc=%0d want gr=%b cc=%0d", sent, gr, cc, e[7:4], e[3:0]);
        end
      end
    end
    checks++;
    if (n !== 3 || sent !== 3) begin
      failures++; $display("FAIL sp_throughput got cycles=%0d strobes=%0d want 3/3", n, sent);
    end
    cyc(0, 4'b0000, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'd0 || bz !== 1'b0 || st !== 1'b0 || cc !== 4'd1) begin
      failures++; $display("FAIL sp_release got gr=%b bz=%b st=%b cc=%0d want 0000/0/0/1", gr, bz, st, cc);
    end
    for (int k = 0; k < 3; k++) cyc(0, 4'b0000, 4'b0000, 1'b1, st, gr, cc, bz);
    cyc(0, 4'b0000, 4'b0000, 1'b1, st, gr, cc, bz);
    checks++;
    if (cc !== 4'd4) begin
      failures++; $display("FAIL sp_refill got=%0d want=4", cc);
    end
    cyc(0, 4'b1111, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (cc !== 4'd4) begin
      failures++; $display("FAIL sp_saturate got=%0d want=4", cc);
    end
    cyc(0, 4'b1111, 4'b1000, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'b1000 || st !== 1'b1) begin
      failures++; $display("FAIL sp_rr_after_ch2 got gr=%b st=%b want 1000/1", gr, st);
    end
    cyc(0, 4'b0000, 4'b0000, 1'b0, st, gr, cc, bz);
  endtask

  task automatic test_round_robin();
    logic st, bz;
    logic [3:0] gr, cc, req;
    logic [7:0] e;
    int pending[4];
    int last, n;
    do_reset();
    sb_q.delete();
    for (int i = 0; i < 4; i++) pending[i] = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) sb_q.push_back({4'(1 << i), 4'd4});
    last = -1; n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      req = 4'd0;
      for (int i = 0; i < 4; i++) if (pending[i] > 0) req[i] = 1'b1;
      cyc(0, req, req, 1'b1, st, gr, cc, bz);
      if (st) begin
        e = sb_q.pop_front();
        checks++;
        if ({gr, cc} !== e) begin
          failures++; $display("FAIL rr_order got gr=%b cc=%0d want gr=%b cc=%0d", gr, cc, e[7:4], e[3:0]);
        end
        if (last >= 0) begin
          checks++;
          if (n - last !== 2) begin
            failures++; $display("FAIL rr_bubble got gap=%0d want=2", n - last);
          end
        end
        last = n;
        for (int i = 0; i < 4; i++) if (e[4 + i]) pending[i]--;
      end
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL rr_timeout got remaining=%0d want=0", sb_q.size());
    end
    sb_q.delete();
    cyc(0, 4'b0000, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'd0 || cc !== 4'd4) begin
      failures++; $display("FAIL rr_end got gr=%b cc=%0d want 0000/4", gr, cc);
    end
  endtask

  task automatic test_no_credit();
    logic st, bz;
    logic [3:0] gr, cc;
    logic [12:0] cr_t, tail_t, st_t, req_t, gr_t;
    int cc_t[13];
    cr_t   = 13'h0640;
    tail_t = 13'h0800;
    st_t   = 13'h0C86;
    req_t  = 13'h0FFF;
    gr_t   = 13'h0FFE;
    cc_t   = '{2, 2, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
    do_reset();
    for (int c = 0; c < 13; c++) begin
      cyc(1, req_t[c] ? 4'b0010 : 4'b0000, tail_t[c] ? 4'b0010 : 4'b0000, cr_t[c], st, gr, cc, bz);
      checks++;
      if (st !== st_t[c]) begin
        failures++; $display("FAIL nc_strobe c%0d got=%b want=%b", c, st, st_t[c]);
      end
      checks++;
      if (cc !== 4'(cc_t[c])) begin
        failures++; $display("FAIL nc_credit c%0d got=%0d want=%0d", c, cc, cc_t[c]);
      end
      checks++;
      if (gr !== (gr_t[c] ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL nc_grant c%0d got=%b want=%b", c, gr, gr_t[c] ? 4'b0010 : 4'b0000);
      end
    end
    checks++;
    if (bz !== 1'b0) begin
      failures++; $display("FAIL nc_busy_end got=%b want=0", bz);
    end
  endtask

  task automatic test_abort();
    logic st, bz;
    logic [3:0] gr, cc;
    do_reset();
    cyc(0, 4'b0010, 4'b0000, 1'b0, st, gr, cc, bz);
    cyc(0, 4'b0010, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (st !== 1'b1 || gr !== 4'b0010) begin
      failures++; $display("FAIL ab_first got st=%b gr=%b want 1/0010", st, gr);
    end
    cyc(0, 4'b0101, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (st !== 1'b0 || gr !== 4'b0010 || bz !== 1'b1) begin
      failures++; $display("FAIL ab_drop got st=%b gr=%b bz=%b want 0/0010/1", st, gr, bz);
    end
    cyc(0, 4'b0101, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'd0 || st !== 1'b0 || bz !== 1'b0 || cc !== 4'd3) begin
      failures++; $display("FAIL ab_release got gr=%b st=%b bz=%b cc=%0d want 0000/0/0/3", gr, st, bz, cc);
    end
    cyc(0, 4'b0101, 4'b0100, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'b0100 || st !== 1'b1) begin
      failures++; $display("FAIL ab_pointer got gr=%b st=%b want 0100/1", gr, st);
    end
    cyc(0, 4'b0000, 4'b0000, 1'b0, st, gr, cc, bz);
  endtask

  task automatic test_async_reset();
    logic st, bz;
    logic [3:0] gr, cc;
    do_reset();
    cyc(0, 4'b0100, 4'b0100, 1'b0, st, gr, cc, bz);
    cyc(0, 4'b0100, 4'b0100, 1'b0, st, gr, cc, bz);
    cyc(0, 4'b0010, 4'b0000, 1'b0, st, gr, cc, bz);
    cyc(0, 4'b0010, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'b0010 || st !== 1'b1) begin
      failures++; $display("FAIL ar_setup got gr=%b st=%b want 0010/1", gr, st);
    end
    a.request_vector_din = 4'b0010;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (a.grant_vector_dout !== 4'd0 || a.port_busy_dout !== 1'b0 || a.transfer_strobe_dout !== 1'b0) begin
      failures++;
      $display("FAIL ar_immediate got gr=%b bz=%b st=%b want 0000/0/0",
               a.grant_vector_dout, a.port_busy_dout, a.transfer_strobe_dout);
    end
    checks++;
    if (a.credit_count_dout !== 4'd4) begin
      failures++; $display("FAIL ar_credit got=%0d want=4", a.credit_count_dout);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(0, 4'b1111, 4'b0000, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'd0 || bz !== 1'b0) begin
      failures++; $display("FAIL ar_idle got gr=%b bz=%b want 0000/0", gr, bz);
    end
    cyc(0, 4'b1111, 4'b0001, 1'b0, st, gr, cc, bz);
    checks++;
    if (gr !== 4'b0001 || st !== 1'b1) begin
      failures++; $display("FAIL ar_rr_zero got gr=%b st=%b want 0001/1", gr, st);
    end
    cyc(0, 4'b0000, 4'b0000, 1'b0, st, gr, cc, bz);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_no_credit();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
